// File: rtl/hier_include_b_accum_pkg.sv
// Shared types and sizes for the block B accumulator: beat, sum, count and result layout.
package hier_include_b_accum_pkg;

    localparam int unsigned B_ANOTHER_SIZE = 9;
    localparam int unsigned B_ACCUM_LEN    = 4;
    localparam int unsigned B_SUM_W        = B_ANOTHER_SIZE + $clog2(B_ACCUM_LEN);
    localparam int unsigned B_CNT_W        = $clog2(B_ACCUM_LEN + 1);
    localparam int unsigned B_ACCUM_W      = B_SUM_W + B_CNT_W;

    typedef logic [B_ANOTHER_SIZE-1:0] b_size_t;
    typedef logic [B_SUM_W-1:0]        b_sum_t;
    typedef logic [B_CNT_W-1:0]        b_cnt_t;

    // Sum sits in the MSBs of the flattened result.
    typedef struct packed {
        b_sum_t sum;
        b_cnt_t count;
    } b_accum_t;

    typedef enum logic {
        BAccum,
        BHold
    } b_accum_state_t;

endpackage

// File: rtl/hier_include_b_accum_if.sv
// Generic valid/ready stream; master drives valid and data, slave drives ready.
interface hier_include_b_accum_if #(
    parameter int unsigned W = 9
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/hier_include_b_out_slot.sv
// One-entry valid/ready holding register for the accumulated result.
module hier_include_b_out_slot #(
    parameter int unsigned W = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [W-1:0]  load_data,
    output logic          busy,
    hier_include_b_accum_if.master out
);

    logic         valid_q;
    logic [W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= load_data;
        end else if (valid_q && out.ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out.valid = valid_q;
    assign out.data  = data_q;
    assign busy      = valid_q;

endmodule

// File: rtl/hier_include_b_accum.sv
// Sums the bAnother field of incoming beats over bursts of ACCUM_LEN (or until flush)
// and emits one {sum, count} result per burst.
module hier_include_b_accum
    import hier_include_b_accum_pkg::*;
#(
    parameter int unsigned ACCUM_LEN = B_ACCUM_LEN,
    localparam int unsigned SUM_W    = B_ANOTHER_SIZE + $clog2(ACCUM_LEN),
    localparam int unsigned CNT_W    = $clog2(ACCUM_LEN + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    hier_include_b_accum_if.slave  in,
    hier_include_b_accum_if.master out
);

    b_accum_state_t   state_q, state_d;
    logic [SUM_W-1:0] acc_sum_q, acc_sum_d;
    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;

    logic             accept;
    logic [SUM_W-1:0] sum_inc;
    logic [CNT_W-1:0] cnt_inc;
    logic             load;
    logic             busy;

    assign in.ready = (state_q == BAccum) && !rst;
    assign accept   = in.valid && in.ready;
    assign sum_inc  = acc_sum_q + (accept ? SUM_W'(in.data) : '0);
    assign cnt_inc  = acc_cnt_q + CNT_W'(accept);

    always_comb begin
        state_d   = state_q;
        acc_sum_d = acc_sum_q;
        acc_cnt_d = acc_cnt_q;
        load      = 1'b0;
        unique case (state_q)
            BAccum: begin
                acc_sum_d = sum_inc;
                acc_cnt_d = cnt_inc;
                // cnt_inc is non-zero exactly when something is pending to close.
                if ((accept && cnt_inc == CNT_W'(ACCUM_LEN)) || (flush && cnt_inc != '0)) begin
                    load      = 1'b1;
                    acc_sum_d = '0;
                    acc_cnt_d = '0;
                    state_d   = BHold;
                end
            end
            BHold: begin
                if (busy && out.ready) begin
                    state_d = BAccum;
                end
            end
            default: state_d = BAccum;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= BAccum;
            acc_sum_q <= '0;
            acc_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_sum_q <= acc_sum_d;
            acc_cnt_q <= acc_cnt_d;
        end
    end

    hier_include_b_out_slot #(
        .W (SUM_W + CNT_W)
    ) u_out_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data ({sum_inc, cnt_inc}),
        .busy      (busy),
        .out       (out)
    );

endmodule

// File: tb/tb_hier_include_b_accum.sv
// Directed bench for hier_include_b_accum with hand-computed burst results.
module tb_hier_include_b_accum;
    import hier_include_b_accum_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    int   checks = 0;
    int   errors = 0;

    hier_include_b_accum_if #(.W(B_ANOTHER_SIZE)) in_if ();
    hier_include_b_accum_if #(.W(B_ACCUM_W))      out_if ();

    hier_include_b_accum dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .in    (in_if.slave),
        .out   (out_if.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] res(input int unsigned sum, input int unsigned cnt);
        return (sum << B_CNT_W) | cnt;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int unsigned v);
        in_if.valid = 1'b1;
        in_if.data  = b_size_t'(v);
        tick();
        in_if.valid = 1'b0;
    endtask

    task automatic expect_result(input string tag, input int unsigned sum,
                                 input int unsigned cnt);
        check({tag, "_valid"}, 32'(out_if.valid), 32'd1);
        check({tag, "_data"}, 32'(out_if.data), res(sum, cnt));
        check({tag, "_in_ready"}, 32'(in_if.ready), 32'd0);
    endtask

    initial begin
        logic [31:0] held;
        in_if.valid  = 1'b0;
        in_if.data   = '0;
        out_if.ready = 1'b1;

        // Reset
        tick();
        tick();
        check("rst_in_ready", 32'(in_if.ready), 32'd0);
        check("rst_out_valid", 32'(out_if.valid), 32'd0);
        check("rst_out_data", 32'(out_if.data), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_if.ready), 32'd1);

        // 1: back-to-back 10,20,30,40
        beat(10); beat(20); beat(30); beat(40);
        expect_result("t1", 100, 4);
        tick();
        check("t1_released", 32'(out_if.valid), 32'd0);
        check("t1_in_ready_back", 32'(in_if.ready), 32'd1);

        // 2: max beats, no wrap
        beat(511); beat(511); beat(511); beat(511);
        expect_result("t2", 2044, 4);
        tick();

        // 3a: partial burst closed by a flush without a beat
        beat(5); beat(7);
        check("t3a_not_yet", 32'(out_if.valid), 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        expect_result("t3a", 12, 2);
        tick();

        // 3b: flush together with a beat
        beat(5);
        in_if.valid = 1'b1;
        in_if.data  = 9'd3;
        flush       = 1'b1;
        tick();
        in_if.valid = 1'b0;
        flush       = 1'b0;
        expect_result("t3b", 8, 2);
        tick();

        // 4: back-pressure holds output; upstream beat waits in HOLD
        out_if.ready = 1'b0;
        beat(1); beat(2); beat(3); beat(4);
        held = 32'(out_if.data);
        check("t4_first", held, res(10, 4));
        in_if.valid = 1'b1;
        in_if.data  = 9'd9;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4_hold_valid", 32'(out_if.valid), 32'd1);
            check("t4_hold_data", 32'(out_if.data), held);
            check("t4_hold_in_ready", 32'(in_if.ready), 32'd0);
        end
        out_if.ready = 1'b1;
        tick();
        check("t4_drained", 32'(out_if.valid), 32'd0);
        check("t4_in_ready", 32'(in_if.ready), 32'd1);
        tick();
        in_if.valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        expect_result("t4_late_beat", 9, 1);
        tick();

        // 5: flush on empty accumulator, and flush during HOLD
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t5_empty_flush", 32'(out_if.valid), 32'd0);
        out_if.ready = 1'b0;
        beat(1); beat(1); beat(1); beat(1);
        expect_result("t5_burst", 4, 4);
        flush = 1'b1;
        tick();
        check("t5_hold_flush", 32'(out_if.data), res(4, 4));
        flush = 1'b0;
        out_if.ready = 1'b1;
        tick();
        check("t5_drain", 32'(out_if.valid), 32'd0);
        tick();
        check("t5_no_second", 32'(out_if.valid), 32'd0);

        // 6a: reset mid-burst discards partial data
        beat(7); beat(8);
        rst = 1'b1;
        #1;
        check("t6a_rst_in_ready", 32'(in_if.ready), 32'd0);
        tick();
        check("t6a_rst_valid", 32'(out_if.valid), 32'd0);
        rst = 1'b0;
        beat(1); beat(1); beat(1); beat(1);
        expect_result("t6a", 4, 4);
        tick();

        // 6b: reset during HOLD discards the pending result
        out_if.ready = 1'b0;
        beat(2); beat(2); beat(2); beat(2);
        expect_result("t6b_hold", 8, 4);
        rst = 1'b1;
        tick();
        check("t6b_rst_valid", 32'(out_if.valid), 32'd0);
        check("t6b_rst_data", 32'(out_if.data), 32'd0);
        rst = 1'b0;
        out_if.ready = 1'b1;
        beat(1); beat(1); beat(1); beat(1);
        expect_result("t6b", 4, 4);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
